// File: rtl/opti_iir_top.sv
// Streaming fixed-point IIR filter: a cascade of NUM_SOS direct-form-I biquads.
// Each section uses three pipeline stages (shift taps, feed-forward sum,
// feedback and saturation). The top block tracks the frame index, completion
// and output settling.
module opti_iir_top #(
  parameter int NUM_SOS     = 2,
  parameter int DATA_W      = 24,
  parameter int COEF_W      = 24,
  parameter int COEF_FRAC   = 22,
  parameter int NUM_SAMPLES = 2048,
  parameter int ADDR_W      = 11,
  parameter int STABLE_TOL  = 16,
  parameter int STABLE_CNT  = 16,
  parameter logic [NUM_SOS*5*COEF_W-1:0] SOS_COEFS =
    {NUM_SOS{{(4*COEF_W){1'b0}}, {(COEF_W-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              filter_done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              stable_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int CNT_W  = $clog2(STABLE_CNT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CNT);
  localparam logic [DATA_W:0]   TOL_V     = (DATA_W+1)'(STABLE_TOL);
  localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] chain_data [NUM_SOS+1];
  logic              chain_vld  [NUM_SOS+1];

  logic                armed_q, done_q, stable_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q;
  logic                out_fire, last_out, done_set, sec_clr, settled;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]     absd;

  assign chain_data[0] = data_in;
  assign chain_vld[0]  = data_in_valid & armed_q & ~start;

  assign out_fire = chain_vld[NUM_SOS];
  assign last_out = (addr_q == LAST_ADDR);
  assign done_set = out_fire & last_out & ~start;
  // Finishing a frame flushes the pipelines so in-flight samples never surface.
  assign sec_clr  = start | done_set;

  for (genvar k = 0; k < NUM_SOS; k++) begin : g_sos
    localparam int BASE = k * 5 * COEF_W;
    localparam logic signed [COEF_W-1:0] B0 = SOS_COEFS[BASE            +: COEF_W];
    localparam logic signed [COEF_W-1:0] B1 = SOS_COEFS[BASE +   COEF_W +: COEF_W];
    localparam logic signed [COEF_W-1:0] B2 = SOS_COEFS[BASE + 2*COEF_W +: COEF_W];
    localparam logic signed [COEF_W-1:0] A1 = SOS_COEFS[BASE + 3*COEF_W +: COEF_W];
    localparam logic signed [COEF_W-1:0] A2 = SOS_COEFS[BASE + 4*COEF_W +: COEF_W];

    logic signed [DATA_W-1:0] x_q [3];
    logic signed [DATA_W-1:0] y_q [2];
    logic signed [DATA_W-1:0] out_q, y_d;
    logic [2:0]               vld_q;
    logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
    logic signed [ACC_W-1:0]  ff_q, ff_d, acc_sum, acc_sh;

    // Feed-forward products, feedback subtraction and saturating rescale.
    always_comb begin
      p_b0    = B0 * x_q[0];
      p_b1    = B1 * x_q[1];
      p_b2    = B2 * x_q[2];
      p_a1    = A1 * y_q[0];
      p_a2    = A2 * y_q[1];
      ff_d    = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2);
      acc_sum = ff_q - ACC_W'(p_a1) - ACC_W'(p_a2);
      acc_sh  = acc_sum >>> COEF_FRAC;
      if ((&acc_sh[ACC_W-1:DATA_W-1]) || !(|acc_sh[ACC_W-1:DATA_W-1]))
        y_d = acc_sh[DATA_W-1:0];
      else
        y_d = acc_sh[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end

    // Three-stage section pipeline; feedback taps update in the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q   <= '{default: '0};
        y_q   <= '{default: '0};
        vld_q <= '0;
        ff_q  <= '0;
        out_q <= '0;
      end else if (sec_clr) begin
        x_q   <= '{default: '0};
        y_q   <= '{default: '0};
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[1:0], chain_vld[k]};
        if (chain_vld[k]) begin
          x_q[2] <= x_q[1];
          x_q[1] <= x_q[0];
          x_q[0] <= chain_data[k];
        end
        if (vld_q[0]) ff_q <= ff_d;
        if (vld_q[1]) begin
          y_q[1] <= y_q[0];
          y_q[0] <= y_d;
          out_q  <= y_d;
        end
      end
    end

    assign chain_data[k+1] = out_q;
    assign chain_vld[k+1]  = vld_q[2];
  end

  // Settling measure: step between consecutive outputs of the frame.
  always_comb begin
    diff    = $signed({chain_data[NUM_SOS][DATA_W-1], chain_data[NUM_SOS]})
            - $signed({prev_q[DATA_W-1], prev_q});
    absd    = diff[DATA_W] ? DATA_W'(0) - diff : diff;
    settled = (absd <= TOL_V);
    cnt_d   = cnt_q;
    if (addr_q == '0 || !settled)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Frame control: arming, output index, completion and settled flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= '0;
    end else if (start) begin
      armed_q  <= 1'b1;
      done_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (out_fire) begin
      prev_q   <= chain_data[NUM_SOS];
      cnt_q    <= cnt_d;
      stable_q <= (cnt_d >= CNT_MAX);
      if (last_out) begin
        done_q  <= 1'b1;
        armed_q <= 1'b0;
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign filter_done    = done_q;
  assign addr           = addr_q;
  assign data_out       = chain_data[NUM_SOS];
  assign data_out_valid = out_fire;
  assign stable_out     = stable_q;

endmodule

// File: tb/tb_opti_iir_top.sv
// Scoreboard bench for opti_iir_top: four instances (default pass-through,
// two-section filter with a short frame, one-section IIR, one-section
// saturating gain) driven with random and directed samples.
module tb_opti_iir_top;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st   [ND];
  logic        dv   [ND];
  logic [23:0] din  [ND];
  logic        done_w [ND];
  logic        dov_w  [ND];
  logic        stab_w [ND];
  logic [23:0] dout_w [ND];
  logic [10:0] addr_w [ND];
  logic [5:0]  addr_b;

  localparam logic [239:0] COEF_B = {24'hE66666, 24'h000000, 24'h000000, 24'hC00000, 24'h600000,
                                     24'h0CCCCD, 24'hD9999A, 24'h100000, 24'h200000, 24'h100000};
  localparam logic [119:0] COEF_C = {24'h000000, 24'hE00000, 24'h000000, 24'h000000, 24'h200000};
  localparam logic [119:0] COEF_D = {96'h0, 24'h7FFFFF};

  opti_iir_top u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .data_in(din[0]), .data_in_valid(dv[0]),
    .filter_done(done_w[0]), .addr(addr_w[0]), .data_out(dout_w[0]),
    .data_out_valid(dov_w[0]), .stable_out(stab_w[0]));

  opti_iir_top #(.NUM_SOS(2), .NUM_SAMPLES(64), .ADDR_W(6), .SOS_COEFS(COEF_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .data_in(din[1]), .data_in_valid(dv[1]),
    .filter_done(done_w[1]), .addr(addr_b), .data_out(dout_w[1]),
    .data_out_valid(dov_w[1]), .stable_out(stab_w[1]));
  assign addr_w[1] = {5'b0, addr_b};

  opti_iir_top #(.NUM_SOS(1), .SOS_COEFS(COEF_C)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .data_in(din[2]), .data_in_valid(dv[2]),
    .filter_done(done_w[2]), .addr(addr_w[2]), .data_out(dout_w[2]),
    .data_out_valid(dov_w[2]), .stable_out(stab_w[2]));

  opti_iir_top #(.NUM_SOS(1), .SOS_COEFS(COEF_D)) u_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .data_in(din[3]), .data_in_valid(dv[3]),
    .filter_done(done_w[3]), .addr(addr_w[3]), .data_out(dout_w[3]),
    .data_out_valid(dov_w[3]), .stable_out(stab_w[3]));

  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] a;
    logic [23:0] y;
  } ent_t;

  ent_t   expq [ND][$];
  int     nvec = 0;
  int     nmis = 0;
  int     cyc  = 0;
  int     nsos  [ND] = '{2, 2, 1, 1};
  int     nsamp [ND] = '{2048, 64, 2048, 2048};
  longint cf [ND][2][5];   // per section: b0, b1, b2, a1, a2
  longint xh [ND][2][2];
  longint yh [ND][2][2];
  int     idx    [ND];
  bit     armed  [ND];
  bit     fl     [ND];
  int     mcnt   [ND];
  bit     mstab  [ND];
  longint mprev  [ND];
  bit     chk_done [ND];
  int     outcnt [ND];
  ent_t   e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  // Reference filter: one sample through all sections, plain recurrence.
  function automatic logic [23:0] model_step(int d, logic [23:0] xin);
    longint v, acc;
    v = longint'($signed(xin));
    for (int s = 0; s < nsos[d]; s++) begin
      acc = cf[d][s][0] * v + cf[d][s][1] * xh[d][s][0] + cf[d][s][2] * xh[d][s][1]
          - cf[d][s][3] * yh[d][s][0] - cf[d][s][4] * yh[d][s][1];
      xh[d][s][1] = xh[d][s][0];
      xh[d][s][0] = v;
      acc = acc >>> 22;
      if (acc > 64'sd8388607)  acc = 64'sd8388607;
      if (acc < -64'sd8388608) acc = -64'sd8388608;
      yh[d][s][1] = yh[d][s][0];
      yh[d][s][0] = acc;
      v = acc;
    end
    return v[23:0];
  endfunction

  task automatic flush(int d, bit arm);
    expq[d].delete();
    for (int s = 0; s < 2; s++)
      for (int t = 0; t < 2; t++) begin
        xh[d][s][t] = 0;
        yh[d][s][t] = 0;
      end
    idx[d]      = 0;
    armed[d]    = arm;
    mcnt[d]     = 0;
    mstab[d]    = 1'b0;
    mprev[d]    = 0;
    chk_done[d] = 1'b0;
    outcnt[d]   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (fl[d]) begin
        flush(d, 1'b1);
        fl[d] = 1'b0;
      end
      st[d] = 1'b0;
      dv[d] = 1'b0;
    end
  endtask

  task automatic issue(int d, logic [23:0] x);
    din[d] = x;
    dv[d]  = 1'b1;
    if (armed[d]) begin
      expq[d].push_back('{cyc: cyc, a: 11'(idx[d]), y: model_step(d, x)});
      idx[d]++;
      if (idx[d] == nsamp[d]) armed[d] = 1'b0;
    end
  endtask

  task automatic do_start(int d);
    st[d] = 1'b1;
    fl[d] = 1'b1;
  endtask

  task automatic check_zero(string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_done"},   d, done_w[d], 0);
      chk({tag, "_addr"},   d, addr_w[d], 0);
      chk({tag, "_dout"},   d, dout_w[d], 0);
      chk({tag, "_valid"},  d, dov_w[d],  0);
      chk({tag, "_stable"}, d, stab_w[d], 0);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (chk_done[d]) begin
          chk("done_after_last", d, done_w[d], 1);
          chk_done[d] = 1'b0;
        end
        if (dov_w[d] === 1'b1) begin
          outcnt[d]++;
          if (expq[d].size() == 0) begin
            chk("unexpected_output", d, dov_w[d], 0);
          end else begin
            e = expq[d].pop_front();
            chk("data", d, dout_w[d], e.y);
            chk("addr", d, addr_w[d], e.a);
            chk("latency", d, cyc - e.cyc, 3 * nsos[d]);
            chk("stable", d, stab_w[d], mstab[d]);
            if (e.a == 11'(nsamp[d] - 1)) begin
              chk("done_early", d, done_w[d], 0);
              chk_done[d] = 1'b1;
            end
            if (e.a == 0)
              mcnt[d] = 0;
            else if ((longint'($signed(e.y)) - mprev[d] <= 16) &&
                     (mprev[d] - longint'($signed(e.y)) <= 16))
              mcnt[d] = (mcnt[d] < 16) ? mcnt[d] + 1 : 16;
            else
              mcnt[d] = 0;
            mprev[d] = longint'($signed(e.y));
            mstab[d] = (mcnt[d] >= 16);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      st[d] = 1'b0; dv[d] = 1'b0; din[d] = '0; fl[d] = 1'b0;
      flush(d, 1'b0);
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 5; k++) cf[d][s][k] = 0;
    end
    cf[0][0][0] = 64'sh400000;
    cf[0][1][0] = 64'sh400000;
    cf[1][0][0] = 64'sh100000;  cf[1][0][1] = 64'sh200000;  cf[1][0][2] = 64'sh100000;
    cf[1][0][3] = -64'sh266666; cf[1][0][4] = 64'sh0CCCCD;
    cf[1][1][0] = 64'sh600000;  cf[1][1][1] = -64'sh400000;
    cf[1][1][4] = -64'sh19999A;
    cf[2][0][0] = 64'sh200000;  cf[2][0][3] = -64'sh200000;
    cf[3][0][0] = 64'sh7FFFFF;

    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;

    // unarmed: inputs must be ignored
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < ND; d++) issue(d, 24'($urandom));
      tick();
    end

    // pass-through ramp on the default instance
    do_start(0); tick();
    for (int k = 1; k <= 7; k++) begin
      issue(0, 24'(k) << 20);
      tick();
    end
    repeat (10) tick();

    // impulse into the one-section IIR
    do_start(2); tick();
    issue(2, 24'h400000); tick();
    for (int i = 0; i < 6; i++) begin issue(2, 24'h0); tick(); end
    repeat (6) tick();

    // saturation extremes
    do_start(3); tick();
    issue(3, 24'h7FFFFF); tick();
    issue(3, 24'h800000); tick();
    issue(3, 24'h000001); tick();
    repeat (6) tick();

    // random traffic on all instances, mid-frame restart on the IIR
    for (int d = 0; d < ND; d++) do_start(d);
    tick();
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < ND; d++) begin
        if (d == 2 && i == 150) do_start(2);
        else if ($urandom_range(0, 3) != 0) issue(d, 24'($urandom));
      end
      tick();
    end
    repeat (12) tick();
    chk("short_frame_done", 1, done_w[1], 1);

    // DC input settles, then a restart clears status
    do_start(0); tick();
    for (int i = 0; i < 30; i++) begin issue(0, 24'h123456); tick(); end
    repeat (8) tick();
    chk("stable_dc", 0, stab_w[0], 1);
    for (int i = 0; i < 5; i++) begin issue(0, 24'h123456); tick(); end
    do_start(0); tick();
    chk("restart_stable", 0, stab_w[0], 0);
    chk("restart_addr",   0, addr_w[0], 0);
    chk("restart_done",   0, done_w[0], 0);
    repeat (10) tick();

    // full frame plus surplus input
    do_start(0); tick();
    for (int i = 0; i < 2058; i++) begin issue(0, 24'($urandom)); tick(); end
    for (int w = 0; w < 40 && done_w[0] !== 1'b1; w++) tick();
    chk("frame_done", 0, done_w[0], 1);
    chk("frame_last_addr", 0, addr_w[0], 2047);
    repeat (12) tick();
    chk("frame_out_count", 0, outcnt[0], 2048);
    do_start(0); tick();
    chk("frame_restart_done", 0, done_w[0], 0);

    // asynchronous reset mid-stream
    for (int d = 0; d < ND; d++) do_start(d);
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < ND; d++) issue(d, 24'($urandom));
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    for (int d = 0; d < ND; d++) flush(d, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < ND; d++) issue(d, 24'($urandom));
      tick();
    end

    repeat (20) tick();
    for (int d = 0; d < ND; d++) chk("queue_drained", d, expq[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
